// File: rtl/updi_mem_ctrl.sv
// Burst controller for a single-port SRAM. It turns a start address and beat count into
// a stream of registered SRAM accesses, which can be stores or loads.
module updi_mem_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              i_resetn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [7:0]        i_req_len,
    input  logic              i_ptr_inc,
    input  logic              i_abort,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_rdata_valid,
    input  logic              i_rdata_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic              o_csb0,
    output logic              o_web0,
    output logic [ADDR_W-1:0] o_addr0,
    output logic [DATA_W-1:0] o_din0,
    input  logic [DATA_W-1:0] i_dout0
);

    typedef enum logic [2:0] {IDLE, WRITE, RD_CMD, RD_WAIT, RD_OUT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] ptr;
        logic [7:0]        cnt;
        logic              inc;
    } burst_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    state_t            state, state_d;
    burst_t            burst, burst_d;
    logic [1:0]        wcnt, wcnt_d;
    logic              csb_d, web_d, done_d, beat;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] din_d, rdata_d;

    assign o_req_ready   = (state == IDLE);
    assign o_wdata_ready = (state == WRITE);
    assign o_rdata_valid = (state == RD_OUT);

    always_comb begin
        state_d = state;
        burst_d = burst;
        wcnt_d  = wcnt;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        addr_d  = o_addr0;
        din_d   = o_din0;
        rdata_d = o_rdata;
        done_d  = 1'b0;
        beat    = 1'b0;

        case (state)
            IDLE: begin
                if (i_req_valid) begin
                    burst_d.ptr = i_req_addr;
                    burst_d.cnt = i_req_len;
                    burst_d.inc = i_ptr_inc;
                    state_d     = i_req_write ? WRITE : RD_CMD;
                end
            end
            WRITE: begin
                if (i_wdata_valid) begin
                    csb_d = 1'b0;
                    web_d = 1'b0;
                    addr_d = burst.ptr;
                    din_d  = i_wdata;
                    beat   = 1'b1;
                end
            end
            RD_CMD: begin
                csb_d   = 1'b0;
                addr_d  = burst.ptr;
                wcnt_d  = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    rdata_d = i_dout0;
                    state_d = RD_OUT;
                end else begin
                    wcnt_d = wcnt + 2'd1;
                end
            end
            RD_OUT: begin
                if (i_rdata_ready) beat = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (beat) begin
            if (burst.inc) burst_d.ptr = burst.ptr + ADDR_W'(1);
            if (burst.cnt == 8'd0) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else begin
                burst_d.cnt = burst.cnt - 8'd1;
                state_d     = (state == WRITE) ? WRITE : RD_CMD;
            end
        end

        // Abort wins over a same-cycle handshake: the beat is dropped and nothing new is issued.
        if (state != IDLE && i_abort) begin
            state_d = IDLE;
            burst_d = burst;
            csb_d   = 1'b1;
            web_d   = 1'b1;
            addr_d  = o_addr0;
            din_d   = o_din0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state   <= IDLE;
            burst   <= '0;
            wcnt    <= '0;
            o_csb0  <= 1'b1;
            o_web0  <= 1'b1;
            o_addr0 <= '0;
            o_din0  <= '0;
            o_rdata <= '0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_d;
            burst   <= burst_d;
            wcnt    <= wcnt_d;
            o_csb0  <= csb_d;
            o_web0  <= web_d;
            o_addr0 <= addr_d;
            o_din0  <= din_d;
            o_rdata <= rdata_d;
            o_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_updi_mem_ctrl.sv
// Bench for updi_mem_ctrl: a table of directed bursts, randomized bursts checked against an
// address/memory reference model, and hand sequences for stall, idle abort and mid-burst reset.
module tb_updi_mem_ctrl;
    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       i_resetn;
    logic       i_req_valid, o_req_ready, i_req_write, i_ptr_inc, i_abort;
    logic [7:0] i_req_addr, i_req_len;
    logic       i_wdata_valid, o_wdata_ready, o_rdata_valid, i_rdata_ready, o_done;
    logic [7:0] i_wdata, o_rdata;
    logic       o_csb0, o_web0;
    logic [7:0] o_addr0, o_din0, i_dout0;

    always #5 clk = ~clk;

    updi_mem_ctrl #(.ADDR_W(8), .DATA_W(8), .READ_LAT(RL)) dut (
        .clk(clk), .i_resetn(i_resetn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_ptr_inc(i_ptr_inc), .i_abort(i_abort),
        .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
        .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
        .o_done(o_done), .o_csb0(o_csb0), .o_web0(o_web0), .o_addr0(o_addr0),
        .o_din0(o_din0), .i_dout0(i_dout0)
    );

    // SRAM environment: write on the edge, read data follows the held address.
    logic [7:0] sram [256];
    logic [7:0] model_mem [256];
    always @(posedge clk) if (!o_csb0 && !o_web0) sram[o_addr0] <= o_din0;
    assign i_dout0 = sram[o_addr0];

    typedef struct { bit we; logic [7:0] addr; logic [7:0] data; int cyc; } acc_t;
    typedef struct {
        bit wr; logic [7:0] addr; logic [7:0] len; bit inc; int pct; int abort_at;
        int dbase; int exp_acc; int exp_done; string name;
    } vec_t;

    acc_t       acc_q [$];
    logic [7:0] rd_q [$];
    int         rd_cyc_q [$];
    acc_t       mon_a;
    int         cyc = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int         tests = 0, fails = 0;
    vec_t       vecs [10];
    vec_t       rv;
    logic [7:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (i_resetn) begin
        if (!o_csb0) begin
            mon_a.we = !o_web0; mon_a.addr = o_addr0; mon_a.data = o_din0; mon_a.cyc = cyc;
            acc_q.push_back(mon_a);
        end
        if (o_done) begin done_cnt++; done_cyc = cyc; end
        if (o_rdata_valid && i_rdata_ready && !i_abort) begin
            rd_q.push_back(o_rdata); rd_cyc_q.push_back(cyc); last_hs_cyc = cyc;
        end
        if (i_wdata_valid && o_wdata_ready && !i_abort) last_hs_cyc = cyc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string t);
        chk({t, "_req_ready"}, 32'(o_req_ready), 1);
        chk({t, "_csb0"}, 32'(o_csb0), 1);
        chk({t, "_web0"}, 32'(o_web0), 1);
        chk({t, "_addr0"}, 32'(o_addr0), 0);
        chk({t, "_din0"}, 32'(o_din0), 0);
        chk({t, "_rdata"}, 32'(o_rdata), 0);
        chk({t, "_rdata_valid"}, 32'(o_rdata_valid), 0);
        chk({t, "_wdata_ready"}, 32'(o_wdata_ready), 0);
        chk({t, "_done"}, 32'(o_done), 0);
    endtask

    task automatic run_burst(input vec_t v);
        logic [7:0] wd [256];
        logic [7:0] a;
        int beats, cycles, n;
        bit aborted, hs;
        for (int i = 0; i < 256; i++) wd[i] = (v.dbase >= 0) ? 8'(v.dbase + i) : 8'($urandom);
        acc_q.delete(); rd_q.delete(); rd_cyc_q.delete(); done_cnt = 0;
        @(posedge clk); #1;
        i_req_valid = 1; i_req_write = v.wr; i_req_addr = v.addr; i_req_len = v.len; i_ptr_inc = v.inc;
        @(negedge clk);
        chk({v.name, "_req_ready"}, 32'(o_req_ready), 1);
        @(posedge clk); #1;
        i_req_valid = 0;
        beats = 0; cycles = 0; aborted = 0;
        while (beats <= int'(v.len) && !aborted && cycles < 5000) begin
            i_abort = (beats == v.abort_at);
            if (v.wr) begin
                i_wdata_valid = (int'($urandom_range(99)) < v.pct);
                i_wdata = wd[beats];
            end else begin
                i_rdata_ready = (int'($urandom_range(99)) < v.pct);
            end
            @(negedge clk);
            hs = v.wr ? (i_wdata_valid && o_wdata_ready) : (i_rdata_ready && o_rdata_valid);
            if (i_abort) aborted = 1;
            else if (hs) beats++;
            @(posedge clk); #1;
            cycles++;
        end
        chk({v.name, "_no_timeout"}, 32'(cycles < 5000), 1);
        i_abort = 0; i_wdata_valid = 0; i_rdata_ready = 0;
        repeat (RL + 4) @(posedge clk);
        @(negedge clk);
        n = acc_q.size();
        chk({v.name, "_acc_count"}, n, v.exp_acc);
        chk({v.name, "_done_count"}, done_cnt, v.exp_done);
        chk({v.name, "_idle_after"}, 32'(o_req_ready), 1);
        if (!v.wr) chk({v.name, "_rd_count"}, rd_q.size(), v.exp_acc);
        if (v.exp_done != 0) chk({v.name, "_done_lat"}, done_cyc - last_hs_cyc, 1);
        for (int i = 0; i < v.exp_acc && i < n; i++) begin
            a = v.inc ? 8'(int'(v.addr) + i) : v.addr;
            chk({v.name, "_acc_addr"}, 32'(acc_q[i].addr), 32'(a));
            chk({v.name, "_acc_we"}, 32'(acc_q[i].we), 32'(v.wr));
            if (v.wr) begin
                chk({v.name, "_acc_data"}, 32'(acc_q[i].data), 32'(wd[i]));
                model_mem[a] = wd[i];
                if (v.pct == 100 && v.abort_at < 0)
                    chk({v.name, "_wr_thru"}, acc_q[i].cyc - acc_q[0].cyc, i);
            end else if (i < rd_q.size()) begin
                chk({v.name, "_rdata"}, 32'(rd_q[i]), 32'(model_mem[a]));
                if (i > 0 && v.pct == 100 && v.abort_at < 0)
                    chk({v.name, "_rd_spacing"}, rd_cyc_q[i] - rd_cyc_q[i-1], RL + 2);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr addr   len   inc pct abort dbase   acc done name
        vecs[0] = '{1, 8'h10, 8'd3, 1, 100, -1, 8'hA0, 4,   1, "st_seq"};
        vecs[1] = '{0, 8'h10, 8'd3, 1, 100, -1, -1,    4,   1, "ld_seq"};
        vecs[2] = '{1, 8'hFE, 8'd2, 1, 100, -1, 8'h51, 3,   1, "st_wrap"};
        vecs[3] = '{0, 8'hFE, 8'd2, 1, 100, -1, -1,    3,   1, "ld_wrap"};
        vecs[4] = '{1, 8'h20, 8'd0, 0, 100, -1, 8'h77, 1,   1, "st_single"};
        vecs[5] = '{1, 8'h40, 8'd7, 1, 50,  -1, -1,    8,   1, "st_gaps"};
        vecs[6] = '{1, 8'h50, 8'd7, 1, 50,  3,  -1,    3,   0, "st_abort"};
        vecs[7] = '{0, 8'h40, 8'd7, 1, 60,  5,  -1,    5,   0, "ld_abort"};
        vecs[8] = '{0, 8'h20, 8'd2, 0, 100, -1, -1,    3,   1, "ld_fixed"};
        vecs[9] = '{1, 8'h00, 8'd255, 1, 100, -1, -1, 256, 1, "st_full"};

        for (int i = 0; i < 256; i++) begin
            sram[i] = 8'($urandom);
            model_mem[i] = sram[i];
        end
        i_resetn = 0; i_req_valid = 0; i_req_write = 0; i_req_addr = 0; i_req_len = 0;
        i_ptr_inc = 0; i_abort = 0; i_wdata_valid = 0; i_wdata = 0; i_rdata_ready = 0;
        #13;
        check_reset_vals("reset");
        @(negedge clk); @(negedge clk);
        i_resetn = 1;

        for (int i = 0; i < 10; i++) run_burst(vecs[i]);

        // Load stalled at a fixed address: data must hold while ready is low.
        acc_q.delete(); rd_q.delete(); rd_cyc_q.delete(); done_cnt = 0;
        @(posedge clk); #1;
        i_req_valid = 1; i_req_write = 0; i_req_addr = 8'h20; i_req_len = 8'd2; i_ptr_inc = 0;
        @(posedge clk); #1;
        i_req_valid = 0;
        for (int k = 0; k < 20 && !o_rdata_valid; k++) @(negedge clk);
        chk("stall_valid_seen", 32'(o_rdata_valid), 1);
        held = o_rdata;
        chk("stall_first_data", 32'(held), 32'(model_mem[8'h20]));
        repeat (5) begin
            @(negedge clk);
            chk("stall_stable", 32'(o_rdata), 32'(held));
            chk("stall_valid_hold", 32'(o_rdata_valid), 1);
        end
        @(posedge clk); #1;
        i_rdata_ready = 1;
        for (int k = 0; k < 60 && done_cnt == 0; k++) @(negedge clk);
        @(negedge clk);
        i_rdata_ready = 0;
        chk("stall_rd_count", rd_q.size(), 3);
        chk("stall_done", done_cnt, 1);
        for (int i = 0; i < rd_q.size(); i++) chk("stall_rdata", 32'(rd_q[i]), 32'(model_mem[8'h20]));
        for (int i = 0; i < acc_q.size(); i++) chk("stall_addr", 32'(acc_q[i].addr), 32'h20);

        // Abort while idle has no effect.
        @(posedge clk); #1;
        i_abort = 1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_abort_ready", 32'(o_req_ready), 1);
            chk("idle_abort_csb", 32'(o_csb0), 1);
        end
        @(posedge clk); #1;
        i_abort = 0;

        // Asynchronous reset in the middle of a load.
        @(posedge clk); #1;
        i_req_valid = 1; i_req_write = 0; i_req_addr = 8'h10; i_req_len = 8'd7; i_ptr_inc = 1;
        i_rdata_ready = 1;
        @(posedge clk); #1;
        i_req_valid = 0;
        repeat (6) @(posedge clk);
        #2 i_resetn = 0;
        #1 check_reset_vals("rst_mid");
        @(negedge clk); @(negedge clk);
        i_resetn = 1; i_rdata_ready = 0;
        acc_q.delete(); done_cnt = 0;
        repeat (5) @(negedge clk);
        chk("rst_no_access", acc_q.size(), 0);
        chk("rst_no_done", done_cnt, 0);
        chk("rst_ready", 32'(o_req_ready), 1);
        run_burst('{1, 8'h80, 8'd3, 1, 100, -1, 8'h30, 4, 1, "post_rst_st"});
        run_burst('{0, 8'h80, 8'd3, 1, 100, -1, -1, 4, 1, "post_rst_ld"});

        for (int r = 0; r < 25; r++) begin
            rv.wr = 1'($urandom_range(1));
            rv.addr = 8'($urandom);
            rv.len = 8'($urandom_range(15));
            rv.inc = 1'($urandom_range(1));
            rv.pct = int'($urandom_range(100, 30));
            rv.abort_at = ($urandom_range(4) == 0) ? int'($urandom_range(int'(rv.len))) : -1;
            rv.dbase = -1;
            rv.exp_acc = (rv.abort_at >= 0) ? rv.abort_at : int'(rv.len) + 1;
            rv.exp_done = (rv.abort_at < 0) ? 1 : 0;
            rv.name = rv.wr ? "rnd_st" : "rnd_ld";
            run_burst(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/updi_mem_ctrl.md
UPDI_MEM_CTRL -- requirements
Module: updi_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, 8, memory address width.
REQ-002 Parameter DATA_W, 8, memory data width.
REQ-003 Parameter READ_LAT, 1, clock edges from the edge that samples a read command to the edge at which i_dout0 is valid (range 1..4).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 i_resetn  input  1  asynchronous, active-low reset.
REQ-006 i_req_valid  input  1  burst request valid.
REQ-007 o_req_ready  output  1  controller idle and able to accept a request.
REQ-008 i_req_write  input  1  1 = store burst, 0 = load burst.
REQ-009 i_req_addr  input  ADDR_W  start address.
REQ-010 i_req_len  input  8  beat count minus one; 0 = 1 beat, 255 = 256 beats.
REQ-011 i_ptr_inc  input  1  1 = post-increment the address after each beat; 0 = fixed address.
REQ-012 i_abort  input  1  terminates the current burst.
REQ-013 i_wdata_valid / o_wdata_ready / i_wdata  in / out / in  1 / 1 / DATA_W  store data stream.
REQ-014 o_rdata_valid / i_rdata_ready / o_rdata  out / in / out  1 / 1 / DATA_W  load data stream.
REQ-015 o_done  output  1  one-cycle pulse when a burst completes normally.
REQ-016 o_csb0, o_web0, o_addr0, o_din0  output  1, 1, ADDR_W, DATA_W  registered SRAM port: active-low chip select, active-low write enable, address, write data.
REQ-017 i_dout0  input  DATA_W  SRAM read data.

Function
REQ-018 States SHALL be IDLE, WRITE, RD_CMD, RD_WAIT, RD_OUT.
REQ-019 o_req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where i_req_valid and o_req_ready are both 1.
REQ-020 On acceptance the controller SHALL latch the address into a pointer, latch i_req_len into a beat counter, and latch i_ptr_inc.
REQ-021 On acceptance the controller SHALL go to WRITE if i_req_write = 1, otherwise to RD_CMD.
REQ-022 WRITE: o_wdata_ready SHALL be 1; each wdata handshake SHALL register o_csb0=0, o_web0=0, o_addr0=pointer and o_din0=i_wdata for exactly one cycle.
REQ-023 WRITE: in any cycle without a wdata handshake, o_csb0 SHALL be 1 in the following cycle, so data gaps produce no memory access.
REQ-024 RD_CMD: the controller SHALL register o_csb0=0, o_web0=1 and o_addr0=pointer for one cycle, then enter RD_WAIT.
REQ-025 RD_WAIT: the controller SHALL wait READ_LAT cycles, capture i_dout0 into o_rdata, and enter RD_OUT.
REQ-026 RD_OUT: o_rdata_valid SHALL be 1 and o_rdata SHALL hold stable until i_rdata_ready = 1; only one load beat is outstanding at any time.
REQ-027 After each beat (wdata handshake or rdata handshake), the pointer SHALL increment by 1 if the latched inc flag is set; it SHALL wrap modulo 2^ADDR_W (0xFF -> 0x00).
REQ-028 After each beat, if the beat counter is 0, the controller SHALL pulse o_done for 1 cycle and return to IDLE.
REQ-029 After each beat, if the beat counter is not 0, the controller SHALL decrement the counter and continue in WRITE or RD_CMD.
REQ-030 When i_abort = 1 in any non-IDLE state, the next state SHALL be IDLE with o_csb0=1, o_rdata_valid=0 and o_done=0; an access already registered onto the SRAM port completes, and no further accesses are issued.
REQ-031 i_abort in IDLE SHALL be ignored; i_abort takes priority over a same-cycle beat handshake, which is then discarded.
REQ-032 Outside WRITE and RD_CMD issue cycles, o_csb0 SHALL be 1 and o_web0 SHALL be 1.
REQ-033 Minimum store throughput SHALL be 1 beat per cycle; load throughput SHALL be 1 beat per READ_LAT+2 cycles when the load stream is not stalled.

Reset
REQ-034 While i_resetn = 0, outputs SHALL be: state IDLE, o_req_ready=1, o_csb0=1, o_web0=1, o_addr0=0, o_din0=0, o_rdata=0, o_rdata_valid=0, o_wdata_ready=0, o_done=0; the pointer and counter SHALL be 0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst immediately, with no o_done and no further SRAM access.

Verification
REQ-036 Store addr=0x10, len=3, inc=1, data A0..A3 back-to-back -> writes at 0x10..0x13 on consecutive cycles; o_done 1 cycle after the last beat.
REQ-037 Load of the same range, i_rdata_ready held at 1 -> o_rdata = A0, A1, A2, A3 in order; each beat spaced READ_LAT+2 cycles.
REQ-038 Store addr=0xFE, len=2, inc=1 -> writes at 0xFE, 0xFF, 0x00.
REQ-039 Load with inc=0 at 0x20 (len=2) while i_rdata_ready is low for 5 cycles -> o_rdata stable while stalled; three beats, each reading 0x20.
REQ-040 Store len=7 with i_wdata_valid toggling -> exactly 8 accesses, o_csb0=1 during gaps; i_abort at beat 3 -> IDLE, o_done stays 0.
REQ-041 i_resetn pulsed low mid-load -> all outputs return to their reset values asynchronously; the next request proceeds normally.
